branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand width in bits.
REQ-002 SHALL provide parameter CNT_W, default 16, width of each statistics counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_funct3  input  3  RV32 branch funct3.
REQ-008 SHALL have ports in_a, in_b  input  XLEN  operands.
REQ-009 SHALL have port in_is_branch  input  1  0 = non-branch; the result is forced not-taken.
REQ-010 SHALL have port in_pred_taken  input  1  front-end prediction.
REQ-011 SHALL have port flush  input  1  kill the held result and any same-cycle request.
REQ-012 SHALL have port out_valid  output  1  result register holds a valid entry.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 SHALL have ports out_taken, out_mispredict, out_illegal  output  1 each  result flags.
REQ-015 SHALL have ports stat_branches, stat_mispredicts  output  CNT_W  statistics counters.

Function
REQ-016 SHALL decode funct3 as: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-017 SHALL use two's-complement compare for BLT/BGE and unsigned compare for BLTU/BGEU over the full XLEN.
REQ-018 SHALL treat funct3 010/011 with in_is_branch=1 as illegal: out_taken=0, out_illegal=1.
REQ-019 SHALL compute out_mispredict = in_is_branch && !illegal && (taken != in_pred_taken), and SHALL force it to 0 for non-branches and for illegal funct3.
REQ-020 SHALL register results with latency exactly 1 cycle: out_valid=1 in the cycle after acceptance.
REQ-021 SHALL drive in_ready = !out_valid || out_ready, which allows back-to-back throughput of 1 per cycle.
REQ-022 SHALL hold all out_* flags stable while out_valid && !out_ready.
REQ-023 SHALL, on flush=1, make out_valid=0 the next cycle, drop any same-cycle request, and not update the counters.
REQ-024 SHALL, on simultaneous flush and output handshake, let flush win; the entry counts as dropped, not consumed.
REQ-025 SHALL update the counters only on an output handshake: stat_branches +1 if the entry was a branch, stat_mispredicts +1 if out_mispredict.
REQ-026 SHALL saturate both counters at 2^CNT_W-1; they SHALL never wrap.

Reset
REQ-027 SHALL, while rst=1, force out_valid=0 and out_taken=out_mispredict=out_illegal=0, and clear both counters to 0.
REQ-028 SHALL make rst override flush and discard any in-flight entry; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL compile the statistics counters only when BRANCH_RESOLVE_STATS_EN is defined.
REQ-030 SHALL, without BRANCH_RESOLVE_STATS_EN, keep the stat_* ports, drive them constant 0, and instantiate no counter flops.

Structure
REQ-031 SHALL place the funct3 encodings (BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU) in shared package branch_pkg for reuse by the decoder.
REQ-032 SHALL isolate the combinational compare/decode in one sub-module, branch_cond, with ports a, b, funct3 -> taken, illegal; registering, handshake and counters stay in branch_resolve.

Verification
REQ-033 SHALL cover: a=0xFFFFFFFF, b=0x00000001, funct3=100, pred=0 -> next cycle out_valid=1, out_taken=1, out_mispredict=1.
REQ-034 SHALL cover: same operands, funct3=110, pred=0 -> out_taken=0, out_mispredict=0.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with a second request pending -> in_ready=0 and outputs stable; second result appears the cycle after out_ready=1.
REQ-036 SHALL cover: flush=1 together with in_valid=1 and a held entry -> out_valid=0 next cycle, counters unchanged.
REQ-037 SHALL cover: funct3=010, in_is_branch=1 -> out_illegal=1, out_taken=0, out_mispredict=0.
REQ-038 SHALL cover: CNT_W=8 with the macro defined, 300 consumed mispredicting branches -> stat_branches=stat_mispredicts=255; with the macro undefined both stay 0.

Source files
------------

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg -- shared definitions for the RV32 branch-resolution slice.
//
// Contents:
//   br_funct3_e   funct3 encodings of the six conditional branches
//   br_result_t   flags carried by one resolved branch
//   br_is_legal() true for the six defined branch funct3 codes
// -----------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
  } br_result_t;

  // 010 and 011 are the only codes in the branch opcode space with no meaning.
  function automatic logic br_is_legal(input logic [2:0] funct3);
    return funct3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond -- purely combinational branch condition evaluator.
//
// Ports:
//   a, b     in  XLEN  operands (rs1, rs2)
//   funct3   in  3     branch funct3
//   taken    out 1     condition holds (0 for illegal codes)
//   illegal  out 1     funct3 is not a defined branch encoding
// -----------------------------------------------------------------------------
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    taken   = 1'b0;
    illegal = !br_is_legal(funct3);
    case (funct3)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt_s;
      BR_GE:   taken = !lt_s;
      BR_LTU:  taken = lt_u;
      BR_GEU:  taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve -- resolves RV32 conditional branches with a one-entry,
// valid/ready result register and optional saturating statistics.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid / in_ready               request handshake
//   in_funct3, in_a, in_b             branch encoding and operands
//   in_is_branch, in_pred_taken       branch qualifier, front-end prediction
//   flush                             drop held result and same-cycle request
//   out_valid / out_ready             result handshake
//   out_taken, out_mispredict,
//   out_illegal                       result flags
//   stat_branches, stat_mispredicts   consumed branches / mispredicts
//
// Configuration:
//   BRANCH_RESOLVE_STATS_EN  when defined, builds the saturating counters;
//                            otherwise stat_* are tied to zero.
// -----------------------------------------------------------------------------
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic             in_is_branch,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  logic       cond_taken;
  logic       cond_illegal;
  br_result_t next_res;
  br_result_t res_q;
  logic       valid_q;
  logic       accept;
  logic       consume;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .a       (in_a),
    .b       (in_b),
    .funct3  (in_funct3),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  // Non-branches resolve as not-taken with no flags; illegal codes only
  // raise out_illegal.
  always_comb begin
    next_res            = '0;
    next_res.illegal    = in_is_branch && cond_illegal;
    next_res.taken      = in_is_branch && !cond_illegal && cond_taken;
    next_res.mispredict = in_is_branch && !cond_illegal &&
                          (cond_taken != in_pred_taken);
  end

  assign in_ready = !valid_q || out_ready;
  // Flush beats both handshakes: the request is dropped and the held entry
  // leaves without being counted.
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = valid_q && out_ready && !flush;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= next_res;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid      = valid_q;
  assign out_taken      = res_q.taken;
  assign out_mispredict = res_q.mispredict;
  assign out_illegal    = res_q.illegal;

`ifdef BRANCH_RESOLVE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             held_branch_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;

  // held_branch_q shadows res_q so the count reflects the entry actually
  // consumed, even when a new request is accepted on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_branch_q <= 1'b0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      if (accept) held_branch_q <= in_is_branch;
      if (consume) begin
        if (held_branch_q && br_cnt_q != CNT_MAX)
          br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (res_q.mispredict && mp_cnt_q != CNT_MAX)
          mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve -- directed self-checking bench for branch_resolve
// (XLEN=32, CNT_W=8). Counter expectations follow BRANCH_RESOLVE_STATS_EN.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

`ifdef BRANCH_RESOLVE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_is_branch;
  logic        in_pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_mispredict;
  logic        out_illegal;
  logic [7:0]  stat_branches;
  logic [7:0]  stat_mispredicts;

  int errors = 0;
  int checks = 0;

  // Saturating reference counts of consumed entries.
  logic [7:0] m_br = 8'd0;
  logic [7:0] m_mp = 8'd0;

  branch_resolve #(.XLEN(32), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_funct3        (in_funct3),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_is_branch     (in_is_branch),
    .in_pred_taken    (in_pred_taken),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_taken        (out_taken),
    .out_mispredict   (out_mispredict),
    .out_illegal      (out_illegal),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic isbr, input logic pred);
    in_funct3     = f3;
    in_a          = a;
    in_b          = b;
    in_is_branch  = isbr;
    in_pred_taken = pred;
  endtask

  task automatic note_consumed(input logic isbr, input logic mp);
    if (isbr && m_br != 8'hFF) m_br = m_br + 8'd1;
    if (mp && m_mp != 8'hFF) m_mp = m_mp + 8'd1;
  endtask

  function automatic logic [15:0] exp_stats();
    return STATS_EN ? {m_br, m_mp} : 16'h0000;
  endfunction

  // One request through an idle pipe, then consumed on the next edge.
  task automatic run_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic isbr, input logic pred,
                         input logic et, input logic em, input logic ei);
    drive(f3, a, b, isbr, pred);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_taken, out_mispredict, out_illegal} !== {1'b1, et, em, ei}) begin
      errors++;
      $display("FAIL %s: {valid,taken,mispredict,illegal} got %b want %b", name,
               {out_valid, out_taken, out_mispredict, out_illegal}, {1'b1, et, em, ei});
    end
    step();
    note_consumed(isbr, em);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: out_valid got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(3'b000, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) step();
    checks++;
    if ({out_valid, out_taken, out_mispredict, out_illegal} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {out_valid, out_taken, out_mispredict, out_illegal});
    end
    checks++;
    if ({stat_branches, stat_mispredicts} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_stats: got %h want 0000", {stat_branches, stat_mispredicts});
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_compare();
    run_vec("blt_signed",   3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_vec("bltu_unsigned",3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("beq_equal",    3'b000, 32'd5,         32'd5,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_vec("bne_equal",    3'b001, 32'd5,         32'd5,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("bge_minmax",   3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("bgeu_minmax",  3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_vec("bge_equal",    3'b101, 32'd3,         32'd3,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_vec("bltu_zero",    3'b110, 32'd0,         32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_vec("blt_maxmin",   3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({stat_branches, stat_mispredicts} !== exp_stats()) begin
      errors++;
      $display("FAIL compare_stats: got %h want %h", {stat_branches, stat_mispredicts}, exp_stats());
    end
  endtask

  task automatic test_illegal_nonbranch();
    run_vec("illegal_010",  3'b010, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_vec("illegal_011",  3'b011, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_vec("non_branch",   3'b000, 32'd7, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_vec("non_branch_010",3'b010,32'd7, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({stat_branches, stat_mispredicts} !== exp_stats()) begin
      errors++;
      $display("FAIL illegal_stats: got %h want %h", {stat_branches, stat_mispredicts}, exp_stats());
    end
  endtask

  task automatic test_backpressure();
    // Entry A: BEQ 1,1 predicted not-taken -> taken, mispredict.
    out_ready = 1'b0;
    drive(3'b000, 32'd1, 32'd1, 1'b1, 1'b0);
    in_valid = 1'b1;
    step();
    // Entry B pending: BNE 1,2 predicted taken -> taken, no mispredict.
    drive(3'b001, 32'd1, 32'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, out_taken, out_mispredict, out_illegal} !== 5'b01110) begin
        errors++;
        $display("FAIL stall_cycle%0d: {in_ready,valid,taken,mp,ill} got %b want 01110", i,
                 {in_ready, out_valid, out_taken, out_mispredict, out_illegal});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_in_ready: got %b want 1", in_ready);
    end
    step();
    note_consumed(1'b1, 1'b1);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_taken, out_mispredict, out_illegal} !== 4'b1100) begin
      errors++;
      $display("FAIL stall_second_result: got %b want 1100",
               {out_valid, out_taken, out_mispredict, out_illegal});
    end
    step();
    note_consumed(1'b1, 1'b0);
    checks++;
    if ({out_valid, stat_branches, stat_mispredicts} !== {1'b0, exp_stats()}) begin
      errors++;
      $display("FAIL stall_drain: {valid,stats} got %h want %h",
               {out_valid, stat_branches, stat_mispredicts}, {1'b0, exp_stats()});
    end
  endtask

  task automatic test_flush();
    // Held entry: BLT -1,1 predicted not-taken (would count as a mispredict).
    out_ready = 1'b0;
    drive(3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    in_valid = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: out_valid got %b want 1", out_valid);
    end
    // Flush with a same-cycle request and a same-cycle output handshake.
    drive(3'b000, 32'd0, 32'd0, 1'b1, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, stat_branches, stat_mispredicts} !== {1'b0, exp_stats()}) begin
      errors++;
      $display("FAIL flush_drop: {valid,stats} got %h want %h",
               {out_valid, stat_branches, stat_mispredicts}, {1'b0, exp_stats()});
    end
    step();
    checks++;
    if ({out_valid, stat_branches, stat_mispredicts} !== {1'b0, exp_stats()}) begin
      errors++;
      $display("FAIL flush_request_dropped: {valid,stats} got %h want %h",
               {out_valid, stat_branches, stat_mispredicts}, {1'b0, exp_stats()});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3 [4] = '{3'b001, 3'b111, 3'b100, 3'b000};
    logic [31:0] av [4] = '{32'd1, 32'd0, 32'h8000_0000, 32'd0};
    logic [31:0] bv [4] = '{32'd2, 32'd1, 32'd0, 32'd1};
    logic        pr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        et [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        em [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(f3[i], av[i], bv[i], 1'b1, pr[i]);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready%0d: got %b want 1", i, in_ready);
      end
      step();
      if (i > 0) note_consumed(1'b1, em[i-1]);
      checks++;
      if ({out_valid, out_taken, out_mispredict, out_illegal} !== {1'b1, et[i], em[i], 1'b0}) begin
        errors++;
        $display("FAIL b2b_result%0d: got %b want %b", i,
                 {out_valid, out_taken, out_mispredict, out_illegal}, {1'b1, et[i], em[i], 1'b0});
      end
    end
    in_valid = 1'b0;
    step();
    note_consumed(1'b1, em[3]);
    checks++;
    if ({out_valid, stat_branches, stat_mispredicts} !== {1'b0, exp_stats()}) begin
      errors++;
      $display("FAIL b2b_drain: {valid,stats} got %h want %h",
               {out_valid, stat_branches, stat_mispredicts}, {1'b0, exp_stats()});
    end
  endtask

  task automatic test_reset_override();
    out_ready = 1'b0;
    drive(3'b000, 32'd9, 32'd9, 1'b1, 1'b0);
    in_valid = 1'b1;
    step();
    rst   = 1'b1;
    flush = 1'b1;
    step();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    m_br     = 8'd0;
    m_mp     = 8'd0;
    checks++;
    if ({in_ready, out_valid, out_taken, out_mispredict, out_illegal, stat_branches, stat_mispredicts}
        !== {5'b10000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_override: {rdy,valid,t,m,i,stats} got %h want %h",
               {in_ready, out_valid, out_taken, out_mispredict, out_illegal,
                stat_branches, stat_mispredicts}, {5'b10000, 16'h0000});
    end
  endtask

  task automatic test_saturation();
    // 300 mispredicting branches streamed at full rate: BEQ 0,0 predicted not-taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(3'b000, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 100) begin
        checks++;
        if ({stat_branches, stat_mispredicts} !== (STATS_EN ? 16'h6464 : 16'h0000)) begin
          errors++;
          $display("FAIL sat_mid: got %h want %h", {stat_branches, stat_mispredicts},
                   STATS_EN ? 16'h6464 : 16'h0000);
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if ({out_valid, stat_branches, stat_mispredicts} !== {1'b0, (STATS_EN ? 16'hFFFF : 16'h0000)}) begin
      errors++;
      $display("FAIL sat_final: {valid,stats} got %h want %h",
               {out_valid, stat_branches, stat_mispredicts},
               {1'b0, (STATS_EN ? 16'hFFFF : 16'h0000)});
    end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_illegal_nonbranch();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_override();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
